// File: rtl/camera_sccb_config_pkg.sv
// Shared definitions for the OV2640 SCCB boot-time configuration engine:
// FSM encoding, SCCB constants and frame helpers.
package camera_sccb_config_pkg;

    // Controller states, in the order a normal word walks through them.
    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StStart,
        StShift,
        StStop,
        StAckRom,
        StGap,
        StDone
    } sccb_state_e;

    // One ROM word: [15:8] sub-address, [7:0] value.
    typedef logic [15:0] rom_word_t;

    localparam logic [7:0]  SCCB_ID_OV2640  = 8'h60;
    localparam rom_word_t   SCCB_SRST_WORD  = 16'h1280;
    localparam int unsigned SCCB_FRAME_BITS = 27;

    // FETCH lasts this many cycles so the ROM index update and its registered
    // output have both settled before reg_data is latched.
    localparam int unsigned FETCH_CYCLES   = 2;
    localparam int unsigned START_QUARTERS = 2;
    localparam int unsigned BIT_QUARTERS   = 4;
    localparam int unsigned STOP_QUARTERS  = 3;

    // 3-phase write frame; the trailing zero of each phase is the ACK slot.
    function automatic logic [SCCB_FRAME_BITS-1:0] sccb_frame(input logic [7:0] id,
                                                              input rom_word_t word);
        return {id, 1'b0, word[15:8], 1'b0, word[7:0], 1'b0};
    endfunction

    // Zero-based bit index of the ACK slots (bits 9, 18 and 27 on the wire).
    function automatic logic is_ack_bit(input logic [4:0] idx);
        return (idx == 5'd8) || (idx == 5'd17) || (idx == 5'd26);
    endfunction

endpackage

// File: rtl/camera_sccb_config_if.sv
// Bundle of the ROM handshake and SCCB pad signals of the configuration engine.
// master: the engine itself; slave: the ROM / pad side.
interface camera_sccb_config_if;
    import camera_sccb_config_pkg::*;

    rom_word_t reg_data;
    logic      reg_not_done;
    logic      next_reg;
    logic      sio_c;
    logic      sio_d_out;
    logic      sio_d_oe;
    logic      busy;
    logic      config_done;

    modport master (
        input  reg_data,
        input  reg_not_done,
        output next_reg,
        output sio_c,
        output sio_d_out,
        output sio_d_oe,
        output busy,
        output config_done
    );

    modport slave (
        output reg_data,
        output reg_not_done,
        input  next_reg,
        input  sio_c,
        input  sio_d_out,
        input  sio_d_oe,
        input  busy,
        input  config_done
    );

endinterface

// File: rtl/camera_sccb_config_quarter_tick.sv
// SCCB quarter-bit prescaler: counts 0..CLK_DIV-1 while enabled and pulses
// tick on the wrap cycle. Held at zero while disabled so every transaction
// starts on a full quarter.
module camera_sccb_config_quarter_tick #(
    parameter int unsigned CLK_DIV = 63
) (
    input  logic camera_clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    // CLK_DIV of 0 behaves as 1 (tick every enabled cycle).
    localparam logic [31:0] LAST = (CLK_DIV > 1) ? 32'(CLK_DIV - 1) : 32'd0;

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Next count and tick decode.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q >= LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Prescaler register, synchronous active-low reset.
    always_ff @(posedge camera_clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/camera_sccb_config.sv
// OV2640 boot-time configuration engine. Pulls {sub-address, value} words from
// the register ROM and writes each as an SCCB 3-phase write, pulsing next_reg
// after every word and raising config_done when the ROM runs dry.
module camera_sccb_config
    import camera_sccb_config_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 63,
    parameter logic [7:0]  DEV_ADDR  = SCCB_ID_OV2640,
    parameter int unsigned BOOT_WAIT = 1_000_000,
    parameter int unsigned GAP_WAIT  = 256,
    parameter int unsigned SRST_WAIT = 25_000
) (
    input logic                   camera_clk,
    input logic                   rst,
    camera_sccb_config_if.master  bus
);

    localparam logic [31:0] BOOT_LAST  = (BOOT_WAIT > 1) ? 32'(BOOT_WAIT - 1) : 32'd0;
    localparam logic [31:0] FETCH_LAST = 32'(FETCH_CYCLES - 1);
    localparam logic [1:0]  START_LAST = 2'(START_QUARTERS - 1);
    localparam logic [1:0]  BIT_LAST_Q = 2'(BIT_QUARTERS - 1);
    localparam logic [1:0]  STOP_LAST  = 2'(STOP_QUARTERS - 1);
    localparam logic [4:0]  LAST_BIT   = 5'(SCCB_FRAME_BITS - 1);

    sccb_state_e                state_q, state_d;
    logic [31:0]                wait_q, wait_d;
    logic [4:0]                 bit_q, bit_d;
    logic [1:0]                 quarter_q, quarter_d;
    logic [SCCB_FRAME_BITS-1:0] shift_q, shift_d;
    logic                       srst_q, srst_d;

    logic        tick;
    logic        tick_en;
    logic [31:0] gap_total;
    logic [31:0] gap_last;

    // The prescaler only runs while the bus is being driven.
    always_comb begin
        tick_en = (state_q == StStart) || (state_q == StShift) || (state_q == StStop);
    end

    camera_sccb_config_quarter_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_quarter_tick (
        .camera_clk (camera_clk),
        .rst        (rst),
        .en         (tick_en),
        .tick       (tick)
    );

    // Inter-word idle time; the soft-reset word needs the sensor to reboot first.
    always_comb begin
        gap_total = 32'(GAP_WAIT) + (srst_q ? 32'(SRST_WAIT) : 32'd0);
        gap_last  = (gap_total > 32'd1) ? (gap_total - 32'd1) : 32'd0;
    end

    // Next-state logic and pin decode, all outputs from registered state only.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        bit_d     = bit_q;
        quarter_d = quarter_q;
        shift_d   = shift_q;
        srst_d    = srst_q;

        bus.sio_c       = 1'b1;
        bus.sio_d_out   = 1'b1;
        bus.sio_d_oe    = 1'b1;
        bus.next_reg    = 1'b0;
        bus.busy        = 1'b1;
        bus.config_done = 1'b0;

        unique case (state_q)
            StBoot: begin
                if (wait_q >= BOOT_LAST) begin
                    state_d = StFetch;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end

            StFetch: begin
                if (wait_q >= FETCH_LAST) begin
                    wait_d = '0;
                    if (!bus.reg_not_done) begin
                        state_d = StDone;
                    end else begin
                        shift_d   = sccb_frame(DEV_ADDR, bus.reg_data);
                        srst_d    = (bus.reg_data == SCCB_SRST_WORD);
                        bit_d     = '0;
                        quarter_d = '0;
                        state_d   = StStart;
                    end
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end

            StStart: begin
                bus.sio_d_out = (quarter_q == 2'd0);
                if (tick) begin
                    if (quarter_q == START_LAST) begin
                        quarter_d = '0;
                        state_d   = StShift;
                    end else begin
                        quarter_d = quarter_q + 2'd1;
                    end
                end
            end

            StShift: begin
                bus.sio_c     = quarter_q[1];
                bus.sio_d_out = shift_q[SCCB_FRAME_BITS-1];
                bus.sio_d_oe  = !is_ack_bit(bit_q);
                if (tick) begin
                    if (quarter_q == BIT_LAST_Q) begin
                        quarter_d = '0;
                        if (bit_q == LAST_BIT) begin
                            state_d = StStop;
                        end else begin
                            bit_d   = bit_q + 5'd1;
                            shift_d = {shift_q[SCCB_FRAME_BITS-2:0], 1'b0};
                        end
                    end else begin
                        quarter_d = quarter_q + 2'd1;
                    end
                end
            end

            StStop: begin
                bus.sio_c     = (quarter_q != 2'd0);
                bus.sio_d_out = (quarter_q == STOP_LAST);
                if (tick) begin
                    if (quarter_q == STOP_LAST) begin
                        quarter_d = '0;
                        state_d   = StAckRom;
                    end else begin
                        quarter_d = quarter_q + 2'd1;
                    end
                end
            end

            StAckRom: begin
                bus.next_reg = 1'b1;
                wait_d       = '0;
                state_d      = StGap;
            end

            StGap: begin
                if (wait_q >= gap_last) begin
                    wait_d  = '0;
                    state_d = StFetch;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end

            StDone: begin
                bus.busy        = 1'b0;
                bus.config_done = 1'b1;
            end

            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // State, counters and frame register; synchronous active-low reset.
    always_ff @(posedge camera_clk) begin
        if (!rst) begin
            state_q   <= StBoot;
            wait_q    <= '0;
            bit_q     <= '0;
            quarter_q <= '0;
            shift_q   <= '0;
            srst_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bit_q     <= bit_d;
            quarter_q <= quarter_d;
            shift_q   <= shift_d;
            srst_q    <= srst_d;
        end
    end

endmodule
